// File: rtl/pipe_pkg.sv
// Shared types and defaults for the IF/ID elastic pipe: payload layout,
// occupancy classification and the default bubble instruction.
package pipe_pkg;

    localparam int PIPE_REGI_SIZE = 16;
    localparam logic [PIPE_REGI_SIZE-1:0] PIPE_NOP_INSTR = '0;

    typedef struct packed {
        logic [PIPE_REGI_SIZE-1:0] pc;
        logic [PIPE_REGI_SIZE-1:0] instr;
    } ifid_payload_t;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occupancy_t;

    function automatic occupancy_t occ_of(input int cnt, input int depth);
        if (cnt == 0) begin
            return EMPTY;
        end
        if (cnt >= depth) begin
            return FULL;
        end
        return PARTIAL;
    endfunction

endpackage

// File: rtl/pipe_ring_buf.sv
// Storage array and wrapping read/write pointers for the elastic pipe.
// DEPTH must be a power of two so pointers wrap by natural overflow.
module pipe_ring_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage carries no reset; its contents only matter once count says so.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/ifid_elastic_pipe.sv
// IF/ID elastic pipe: DEPTH-entry ring buffer of {next_pc, instr} with
// valid/ready on both sides, flush, and a NOP bubble when empty.
// Optional stall/flush statistics are enabled by IFID_PIPE_STATS_EN.
module ifid_elastic_pipe
    import pipe_pkg::*;
#(
    parameter int                   REGI_SIZE = PIPE_REGI_SIZE,
    parameter int                   DEPTH     = 2,
    parameter logic [REGI_SIZE-1:0] NOP_INSTR = REGI_SIZE'(PIPE_NOP_INSTR)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [REGI_SIZE-1:0]    next_pc_i,
    input  logic [REGI_SIZE-1:0]    instr_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [REGI_SIZE-1:0]    next_pc_o,
    output logic [REGI_SIZE-1:0]    instr_o,
    output logic [$clog2(DEPTH):0]  count_o
`ifdef IFID_PIPE_STATS_EN
    ,
    output logic [31:0]             stall_cnt_o,
    output logic [15:0]             flush_cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PAY_W = 2 * REGI_SIZE;

    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nxt;
    logic                 ready;
    logic                 push;
    logic                 pop;
    logic [REGI_SIZE-1:0] last_pc;
    logic [PAY_W-1:0]     rd_word;
    logic [REGI_SIZE-1:0] head_pc;
    logic [REGI_SIZE-1:0] head_instr;
    occupancy_t           occ_nxt;

    always_comb begin
        push      = valid_i & ready;
        pop       = (count != '0) & ready_i;
        count_nxt = count;
        if (flush_i) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
        occ_nxt = occ_of(int'(count_nxt), DEPTH);
    end

    pipe_ring_buf #(
        .WIDTH (PAY_W),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .clear   (flush_i),
        .push    (push & ~flush_i),
        .pop     (pop & ~flush_i),
        .wr_data ({next_pc_i, instr_i}),
        .rd_data (rd_word)
    );

    assign head_pc    = rd_word[PAY_W-1 -: REGI_SIZE];
    assign head_instr = rd_word[REGI_SIZE-1:0];

    // ready stays low through reset and rises on the first edge after release;
    // it depends only on the registered next occupancy, never on ready_i directly.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count   <= '0;
            ready   <= 1'b0;
            last_pc <= '0;
        end else begin
            count <= count_nxt;
            ready <= (occ_nxt != FULL);
            if (count != '0) begin
                last_pc <= head_pc;
            end
        end
    end

    assign valid_o   = (count != '0);
    assign ready_o   = ready;
    assign count_o   = count;
    assign next_pc_o = valid_o ? head_pc : last_pc;
    assign instr_o   = valid_o ? head_instr : NOP_INSTR;

`ifdef IFID_PIPE_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (valid_o && !ready_i) begin
                stall_cnt <= sat_inc32(stall_cnt);
            end
            if (flush_i) begin
                flush_cnt <= sat_inc16(flush_cnt);
            end
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`endif

endmodule

// File: doc/ifid_elastic_pipe.md
Name: ifid_elastic_pipe

Overview:
Parametrised successor to the single-register IF/ID pipe. It sits between the fetch stage and the decoder and carries {next_pc, instr} through a DEPTH-entry elastic ring buffer. It uses a valid/ready handshake on both sides, so fetch can run ahead while decode stalls. It supports a synchronous flush for branch redirects and drives a configurable NOP bubble to decode when empty.

Parameters:
REGI_SIZE, 16, width of next_pc and instr words
DEPTH, 2, buffer entries; power of two, >= 2
NOP_INSTR, 0, instr_o value driven while valid_o = 0

Ports:
clk_i  in  1  clock, rising-edge
rst_i  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous flush (branch/jump redirect)
valid_i  in  1  fetch presents a word
ready_o  out  1  pipe can accept (registered)
next_pc_i  in  REGI_SIZE  PC from fetch
instr_i  in  REGI_SIZE  instruction from fetch
valid_o  out  1  head entry valid to decode
ready_i  in  1  decode accepts head
next_pc_o  out  REGI_SIZE  head PC
instr_o  out  REGI_SIZE  head instruction, or NOP_INSTR when empty
count_o  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - wr_ptr, rd_ptr and count clear to 0.
  - valid_o = 0, ready_o = 0, next_pc_o = 0, instr_o = NOP_INSTR, count_o = 0.
  - Storage contents are don't-care.
- ready_o is a registered flag. It rises the first clock edge after reset release. Afterwards it is registered from next_count < DEPTH. There is no combinational path from ready_i to ready_o.
- Push = valid_i & ready_o. Pop = valid_o & ready_i. valid_o = (count != 0).
- Push at edge N writes mem[wr_ptr] and increments wr_ptr, wrapping at DEPTH.
- Latency: with the buffer empty, a push at edge N gives valid_o = 1 with that data after edge N (1 cycle). No bypass.
- next_pc_o/instr_o are read from mem[rd_ptr]. instr_o is muxed to NOP_INSTR when count = 0. next_pc_o holds its last value when empty.
- Count update:
  - push only: +1
  - pop only: -1
  - push & pop together: unchanged, both pointers advance
- Full (count = DEPTH): ready_o = 0, so valid_i is ignored. A pop at full frees one slot, and ready_o rises the next cycle.
- Empty: a pop cannot occur, because valid_o = 0.
- Flush: on an edge with flush_i = 1, pointers and count clear to 0, so valid_o = 0 next cycle.
  - A simultaneous push or pop in that cycle is discarded; flush wins.
  - ready_o = 1 after a flush.
- Reset mid-operation: outputs go to reset values immediately and in-flight data is lost.
- Occupancy states (derived from count, no separate state register):
  - EMPTY (0)
  - PARTIAL (1..DEPTH-1)
  - FULL (DEPTH)
- Pointer width is $clog2(DEPTH). Count width is one bit more, to represent FULL.

Optional Feature:
IFID_PIPE_STATS_EN
- Defined: adds outputs stall_cnt_o [31:0] and flush_cnt_o [15:0], both reset to 0.
  - stall_cnt_o increments each cycle valid_o & !ready_i.
  - flush_cnt_o increments each edge with flush_i = 1.
  - Both saturate at all-ones and do not wrap.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - REGI_SIZE default
  - NOP_INSTR constant
  - ifid_payload_t packed struct {pc, instr}
  - occupancy enum {EMPTY, PARTIAL, FULL}, used for debug/assertions
- Sub-module pipe_ring_buf holds the storage array and pointer wrap, parametrised by width and DEPTH. ifid_elastic_pipe owns count, handshake, flush and the NOP mux.

Test Plan:
- Reset release, valid_i = 1, pc = 0x0004, instr = 0xA123, ready_i = 1 -> ready_o = 1 one cycle after release; valid_o = 1 with 0x0004/0xA123 one cycle after the push.
- DEPTH = 2, ready_i = 0, push 0x0010, 0x0012, 0x0014 -> count_o = 2, ready_o = 0, third word not accepted. Raise ready_i -> outputs 0x0010 then 0x0012 in order, and 0x0014 is accepted after ready_o returns to 1.
- Streaming push & pop every cycle over 8 words -> count_o stays 1, order preserved, pointers wrap with no loss.
- Full buffer plus flush_i with valid_i = 1 -> next cycle count_o = 0, valid_o = 0, instr_o = NOP_INSTR, ready_o = 1, pushed word dropped.
- rst_i pulled low mid-stream with count = 2 -> valid_o = 0, ready_o = 0 immediately (asynchronous). After release, the first output is new data only.
- IFID_PIPE_STATS_EN: hold ready_i = 0 for 5 cycles with valid_o = 1, then flush twice -> stall_cnt_o = 5, flush_cnt_o = 2.
